clock_set_ctrl: RTL and testbench

- Timekeeping and time-set controller for the digital clock.
- Consumes the three one-cycle button pulses produced by the button edge detector: mode, increment and decrement.
- Keeps HH:MM:SS running from an internal 1 Hz prescaler, and lets the user edit hours, minutes and seconds in turn.
- Feeds the display/segment driver with the current time fields, the field being edited and a blink phase.

---
 rtl/clock_pkg.sv | 29 ++
 rtl/mod_counter.sv | 36 +++
 rtl/clock_set_ctrl.sv | 158 +++++++++++++++
 tb/tb_clock_set_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the digital clock: edit-state encoding (also decoded
// by the display driver through edit_field) and the time field limits.
// -----------------------------------------------------------------------------
package clock_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_e;

    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;
    localparam int SEC_MAX  = 59;

    // Edit-state order followed on each mode pulse.
    function automatic state_e next_state(input state_e s);
        case (s)
            RUN:     next_state = SET_H;
            SET_H:   next_state = SET_M;
            SET_M:   next_state = SET_S;
            default: next_state = RUN;
        endcase
    endfunction

endpackage

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
// Up/down counter over 0..MAX with wrap in both directions.
//   clk, rst : clock, asynchronous active-high reset (count -> 0)
//   inc, dec : step up / down; both together hold the count
//   count    : registered value
//   carry    : high while an up-step wraps MAX -> 0 (feeds the next field)
// -----------------------------------------------------------------------------
module mod_counter #(
    parameter int MAX = 59,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         carry
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !dec) begin
            count <= (count == MAX_V) ? '0 : count + 1'b1;
        end else if (dec && !inc) begin
            count <= (count == '0) ? MAX_V : count - 1'b1;
        end
    end

    // Combinational so a full 23:59:59 rollover resolves in one cycle.
    assign carry = inc && !dec && (count == MAX_V);

endmodule

// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
// Timekeeping and time-set controller. Runs HH:MM:SS from a 1 Hz prescaler and
// lets the user edit hours, minutes and seconds with mode/inc/dec pulses.
//   clk, rst            : clock, asynchronous active-high reset
//   btn_mode            : advance RUN -> SET_H -> SET_M -> SET_S -> RUN
//   btn_inc, btn_dec    : step the edited field (ignored in RUN)
//   hour/minute/second  : current time
//   edit_field          : 0 RUN, 1 hour, 2 minute, 3 second
//   blink               : blink phase of the edited field, 0 in RUN
//   sec_tick            : one-cycle pulse per running second
// Optional: define CLOCK_SET_TIMEOUT_EN to leave set mode after TIMEOUT_S idle
// seconds, keeping the edited values.
// -----------------------------------------------------------------------------
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BLINK_DIV = 4,
    parameter int TIMEOUT_S = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    output logic [4:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic [1:0] edit_field,
    output logic       blink,
    output logic       sec_tick
);

    localparam int PW = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

    localparam int BLINK_PER = (CLK_HZ / BLINK_DIV < 1) ? 1 : CLK_HZ / BLINK_DIV;
    localparam int BW        = (BLINK_PER > 1) ? $clog2(BLINK_PER) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PER - 1);

    state_e        state;
    logic [PW-1:0] presc;
    logic [BW-1:0] blink_cnt;

    logic run, edit_ok, tick, any_btn, timeout_hit;
    logic sec_inc, sec_dec, min_inc, min_dec, hour_inc, hour_dec;
    logic sec_carry, min_carry, unused_hour_carry;

    assign run     = (state == RUN);
    assign edit_ok = !run && !btn_mode;   // mode wins over inc/dec
    assign tick    = run && (presc == PRESC_LAST);
    assign any_btn = btn_mode || btn_inc || btn_dec;

    // Running: carry chain. Editing: only the selected field moves.
    assign sec_inc  = run ? tick      : (state == SET_S) && edit_ok && btn_inc;
    assign sec_dec  =                   (state == SET_S) && edit_ok && btn_dec;
    assign min_inc  = run ? sec_carry : (state == SET_M) && edit_ok && btn_inc;
    assign min_dec  =                   (state == SET_M) && edit_ok && btn_dec;
    assign hour_inc = run ? min_carry : (state == SET_H) && edit_ok && btn_inc;
    assign hour_dec =                   (state == SET_H) && edit_ok && btn_dec;

    mod_counter #(.MAX(SEC_MAX), .W(6)) u_sec (
        .clk(clk), .rst(rst), .inc(sec_inc), .dec(sec_dec),
        .count(second), .carry(sec_carry)
    );

    mod_counter #(.MAX(MIN_MAX), .W(6)) u_min (
        .clk(clk), .rst(rst), .inc(min_inc), .dec(min_dec),
        .count(minute), .carry(min_carry)
    );

    mod_counter #(.MAX(HOUR_MAX), .W(5)) u_hour (
        .clk(clk), .rst(rst), .inc(hour_inc), .dec(hour_dec),
        .count(hour), .carry(unused_hour_carry)
    );

`ifdef CLOCK_SET_TIMEOUT_EN
    // Idle seconds in set mode, counted with a private divider because the
    // main prescaler is parked at 0 while editing.
    localparam int IW = $clog2(TIMEOUT_S + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_S - 1);

    logic [PW-1:0] idle_div;
    logic [IW-1:0] idle_sec;

    assign timeout_hit = !run && !any_btn && (idle_div == PRESC_LAST) &&
                         (idle_sec == IDLE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_div <= '0;
            idle_sec <= '0;
        end else if (run || any_btn || timeout_hit) begin
            idle_div <= '0;
            idle_sec <= '0;
        end else if (idle_div == PRESC_LAST) begin
            idle_div <= '0;
            idle_sec <= idle_sec + 1'b1;
        end else begin
            idle_div <= idle_div + 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_S > 0);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            presc     <= '0;
            sec_tick  <= 1'b0;
            blink     <= 1'b0;
            blink_cnt <= '0;
        end else begin
            sec_tick <= tick;
            if (run) begin
                blink     <= 1'b0;
                blink_cnt <= '0;
                if (btn_mode) begin
                    state <= SET_H;
                    presc <= '0;
                end else begin
                    presc <= tick ? '0 : presc + 1'b1;
                end
            end else begin
                // Held at 0 so the first second after exit is a full one.
                presc <= '0;
                if (btn_mode || timeout_hit) begin
                    state <= btn_mode ? next_state(state) : RUN;
                    if (timeout_hit || state == SET_S) begin
                        blink     <= 1'b0;
                        blink_cnt <= '0;
                    end else if (blink_cnt == BLINK_LAST) begin
                        blink     <= ~blink;
                        blink_cnt <= '0;
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end
                end else if (btn_inc || btn_dec) begin
                    // Show the value just edited, restart the blink period.
                    blink     <= 1'b1;
                    blink_cnt <= '0;
                end else if (blink_cnt == BLINK_LAST) begin
                    blink     <= ~blink;
                    blink_cnt <= '0;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    assign edit_field = state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
module tb_clock_set_ctrl;

    localparam int CLK_HZ    = 10;
    localparam int BLINK_DIV = 4;
    localparam int TIMEOUT_S = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc  = 1'b0;
    logic       btn_dec  = 1'b0;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic [1:0] edit_field;
    logic       blink;
    logic       sec_tick;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clock_set_ctrl #(
        .CLK_HZ(CLK_HZ), .BLINK_DIV(BLINK_DIV), .TIMEOUT_S(TIMEOUT_S)
    ) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .btn_dec(btn_dec), .hour(hour), .minute(minute), .second(second),
        .edit_field(edit_field), .blink(blink), .sec_tick(sec_tick)
    );

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    // One-cycle pulse; returns #1 after the edge that consumed it.
    task automatic pulse(input logic m, input logic i, input logic d);
        @(posedge clk); #1;
        btn_mode = m; btn_inc = i; btn_dec = d;
        @(posedge clk); #1;
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        checks++;
        if ({hour, minute, second, edit_field, blink, sec_tick} !== 21'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d:%0d:%0d ef=%0d bl=%0b tk=%0b, want all 0",
                     hour, minute, second, edit_field, blink, sec_tick);
        end
        rst = 1'b0;
    endtask

    task automatic test_run();
        int ticks = 0;
        do_reset();
        repeat (600) begin
            @(posedge clk); #1;
            if (sec_tick) ticks++;
        end
        checks++;
        if (minute !== 6'd1 || second !== 6'd0 || hour !== 5'd0) begin
            errors++;
            $display("FAIL run_600: got %0d:%0d:%0d, want 0:1:0", hour, minute, second);
        end
        checks++;
        if (ticks !== 60) begin
            errors++;
            $display("FAIL run_ticks: got %0d, want 60", ticks);
        end
        checks++;
        if (edit_field !== 2'd0 || blink !== 1'b0) begin
            errors++;
            $display("FAIL run_mode: ef=%0d bl=%0b, want 0 0", edit_field, blink);
        end
    endtask

    task automatic test_hour_dec();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        checks++;
        if (edit_field !== 2'd1 || blink !== 1'b0) begin
            errors++;
            $display("FAIL enter_set_h: ef=%0d bl=%0b, want 1 0", edit_field, blink);
        end
        pulse(1'b0, 1'b0, 1'b1);
        checks++;
        if (hour !== 5'd23 || minute !== 6'd0 || second !== 6'd0) begin
            errors++;
            $display("FAIL hour_dec_wrap: got %0d:%0d:%0d, want 23:0:0", hour, minute, second);
        end
        checks++;
        if (blink !== 1'b1) begin
            errors++;
            $display("FAIL hour_dec_blink: got %0b, want 1", blink);
        end
    endtask

    task automatic test_blink();
        logic exp [0:3];
        exp[0] = 1'b0; exp[1] = 1'b1; exp[2] = 1'b1; exp[3] = 1'b0;
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            wait_cyc(1);
            checks++;
            if (blink !== exp[k]) begin
                errors++;
                $display("FAIL blink_phase%0d: got %0b, want %0b", k, blink, exp[k]);
            end
        end
        pulse(1'b0, 1'b1, 1'b0);
        checks++;
        if (blink !== 1'b1 || hour !== 5'd1) begin
            errors++;
            $display("FAIL blink_force: bl=%0b hour=%0d, want 1 1", blink, hour);
        end
        wait_cyc(2);
        checks++;
        if (blink !== 1'b0) begin
            errors++;
            $display("FAIL blink_after_force: got %0b, want 0", blink);
        end
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        checks++;
        if (edit_field !== 2'd0 || blink !== 1'b0) begin
            errors++;
            $display("FAIL blink_exit_run: ef=%0d bl=%0b, want 0 0", edit_field, blink);
        end
    endtask

    task automatic test_min_wrap();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);          // hour 1
        pulse(1'b1, 1'b0, 1'b0);          // SET_M
        pulse(1'b0, 1'b0, 1'b1);          // minute 59
        checks++;
        if (minute !== 6'd59 || edit_field !== 2'd2) begin
            errors++;
            $display("FAIL min_dec_wrap: min=%0d ef=%0d, want 59 2", minute, edit_field);
        end
        pulse(1'b0, 1'b1, 1'b0);
        checks++;
        if (minute !== 6'd0 || hour !== 5'd1 || second !== 6'd0) begin
            errors++;
            $display("FAIL min_inc_nocarry: got %0d:%0d:%0d, want 1:0:0", hour, minute, second);
        end
        pulse(1'b0, 1'b1, 1'b1);
        checks++;
        if (minute !== 6'd0) begin
            errors++;
            $display("FAIL inc_dec_same: min=%0d, want 0", minute);
        end
    endtask

    task automatic test_mode_priority();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b1, 1'b0);
        checks++;
        if (edit_field !== 2'd2 || hour !== 5'd0 || minute !== 6'd0) begin
            errors++;
            $display("FAIL mode_priority: ef=%0d hour=%0d min=%0d, want 2 0 0",
                     edit_field, hour, minute);
        end
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        checks++;
        if (second !== 6'd1 || edit_field !== 2'd3) begin
            errors++;
            $display("FAIL sec_inc: sec=%0d ef=%0d, want 1 3", second, edit_field);
        end
        @(posedge clk); #3 rst = 1'b1;
        #1;
        checks++;
        if ({hour, minute, second, edit_field, blink, sec_tick} !== 21'd0) begin
            errors++;
            $display("FAIL async_reset: got %0d:%0d:%0d ef=%0d bl=%0b, want all 0",
                     hour, minute, second, edit_field, blink);
        end
        #1 rst = 1'b0;
    endtask

    task automatic test_full_carry();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);          // back to RUN
        checks++;
        if (hour !== 5'd23 || minute !== 6'd59 || second !== 6'd59 ||
            edit_field !== 2'd0 || blink !== 1'b0) begin
            errors++;
            $display("FAIL preload: got %0d:%0d:%0d ef=%0d bl=%0b, want 23:59:59 0 0",
                     hour, minute, second, edit_field, blink);
        end
        wait_cyc(CLK_HZ - 1);
        checks++;
        if (sec_tick !== 1'b0 || second !== 6'd59) begin
            errors++;
            $display("FAIL early_tick: tk=%0b sec=%0d, want 0 59", sec_tick, second);
        end
        wait_cyc(1);
        checks++;
        if (hour !== 5'd0 || minute !== 6'd0 || second !== 6'd0 || sec_tick !== 1'b1) begin
            errors++;
            $display("FAIL full_carry: got %0d:%0d:%0d tk=%0b, want 0:0:0 1",
                     hour, minute, second, sec_tick);
        end
        wait_cyc(1);
        checks++;
        if (sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL tick_width: got %0b, want 0", sec_tick);
        end
    endtask

    task automatic test_timeout();
        logic [1:0] exp_ef;
`ifdef CLOCK_SET_TIMEOUT_EN
        exp_ef = 2'd0;
`else
        exp_ef = 2'd1;
`endif
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);          // hour 23, idle restarts here
        wait_cyc(CLK_HZ * TIMEOUT_S - 1);
        checks++;
        if (edit_field !== 2'd1) begin
            errors++;
            $display("FAIL timeout_early: ef=%0d, want 1", edit_field);
        end
        wait_cyc(1);
        checks++;
        if (edit_field !== exp_ef || hour !== 5'd23 || blink === 1'bx) begin
            errors++;
            $display("FAIL timeout: ef=%0d hour=%0d, want %0d 23", edit_field, hour, exp_ef);
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_hour_dec();
        test_blink();
        test_min_wrap();
        test_mode_priority();
        test_full_carry();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
